// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the PISO serializer feeding the sequence detector.
package piso_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } piso_state_e;

  // Bit counter width; never below 1 so WIDTH=2 still gets a real counter bit.
  function automatic int cnt_w(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/piso_hold_reg.sv
// One-entry pending word buffer; the top loads it mid-word and drains it at a last-bit edge.
module piso_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] pend_data,
  output logic             pend_full
);

  // load and drain are mutually exclusive: a full buffer blocks accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_data <= '0;
      pend_full <= 1'b0;
    end else if (load) begin
      pend_data <= din;
      pend_full <= 1'b1;
    end else if (drain) begin
      pend_full <= 1'b0;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: valid/ready word intake, one bit per bit_en on d_out/d_valid.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter int   MSB_FIRST = 1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             bit_en,
  output logic             d_out,
  output logic             d_valid
);

  localparam int            BW      = cnt_w(WIDTH);
  localparam int            OUT_IDX = (MSB_FIRST != 0) ? WIDTH-1 : 0;
  localparam logic [BW-1:0] LAST    = BW'(WIDTH-1);

  piso_state_e      state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [BW-1:0]    bcnt, bcnt_n;
  logic [WIDTH-1:0] pend_data;
  logic             pend_full;
  logic             pend_load, pend_drain;
  logic             busy, accept, consume, last;

  assign busy     = (state == S_SHIFT);
  assign in_ready = !pend_full;
  assign accept   = in_valid && in_ready;
  assign consume  = busy && bit_en;
  assign last     = (bcnt == LAST);

  piso_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (pend_load),
    .drain     (pend_drain),
    .din       (in_data),
    .pend_data (pend_data),
    .pend_full (pend_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      shreg <= '0;
      bcnt  <= '0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      bcnt  <= bcnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    bcnt_n     = bcnt;
    pend_load  = 1'b0;
    pend_drain = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          shreg_n = in_data;
          bcnt_n  = '0;
          state_n = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (consume && !last) begin
          shreg_n = (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
          bcnt_n  = bcnt + BW'(1);
        end else if (consume && last) begin
          // Pending word wins over a same-edge accept; accept is blocked while full anyway.
          if (pend_full) begin
            shreg_n    = pend_data;
            bcnt_n     = '0;
            pend_drain = 1'b1;
          end else if (accept) begin
            shreg_n = in_data;
            bcnt_n  = '0;
          end else begin
            state_n = S_IDLE;
          end
        end
        if (accept && !(consume && last)) pend_load = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    d_valid = busy;
    d_out   = busy ? shreg[OUT_IDX] : IDLE_BIT;
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench for piso_serializer (MSB-first/idle-0 and LSB-first/idle-1 instances).
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst_n, bit_en;
  logic [7:0] in_data, in_data2;
  logic       in_valid, in_valid2;
  logic       in_ready, in_ready2;
  logic       d_out, d_out2, d_valid, d_valid2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .bit_en(bit_en), .d_out(d_out), .d_valid(d_valid)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(0), .IDLE_BIT(1'b1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .bit_en(bit_en), .d_out(d_out2), .d_valid(d_valid2)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  w;
    logic [15:0] s;

    rst_n = 1'b0; bit_en = 1'b1;
    in_data = '0; in_valid = 1'b0; in_data2 = '0; in_valid2 = 1'b0;

    // Reset values, then hold after release with no input
    tick(); tick();
    chk("rst_dvalid", d_valid, 0);
    chk("rst_dout",   d_out,   0);
    chk("rst_ready",  in_ready, 1);
    chk("rst_dout2",  d_out2,  1);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_dvalid", d_valid, 0);
      chk("idle_dout",   d_out,   0);
      chk("idle_ready",  in_ready, 1);
    end

    // Single word 96, MSB first, exactly 8 valid cycles
    w = 8'h96;
    in_data = w; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("w96_dvalid", d_valid, 1);
      chk("w96_dout",   d_out,   w[7-i]);
      tick();
    end
    chk("w96_end_dvalid", d_valid, 0);
    chk("w96_end_dout",   d_out,   0);

    // A5 then 3C back-to-back through the pending buffer
    s = 16'hA53C;
    in_data = 8'hA5; in_valid = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      chk("b2b_dvalid", d_valid, 1);
      chk("b2b_dout",   d_out,   s[15-i]);
      chk("b2b_ready",  in_ready, (i >= 1 && i <= 7) ? 1'b0 : 1'b1);
      if (i == 0) in_data = 8'h3C;
      if (i == 1) in_valid = 1'b0;
      tick();
    end
    chk("b2b_end_dvalid", d_valid, 0);

    // C3 with bit_en every second cycle: each bit held two cycles
    w = 8'hC3;
    bit_en = 1'b0; in_data = w; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int j = 0; j < 16; j++) begin
      chk("slow_dvalid", d_valid, 1);
      chk("slow_dout",   d_out,   w[7-(j/2)]);
      bit_en = (j % 2 == 1);
      tick();
    end
    chk("slow_end_dvalid", d_valid, 0);
    bit_en = 1'b1;

    // F0 plus pending FF, reset mid-word after 3 bits
    w = 8'hF0;
    in_data = w; in_valid = 1'b1;
    tick();
    in_data = 8'hFF;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("rstmid_pre_dout",  d_out,    w[4]);
    chk("rstmid_pre_ready", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("rstmid_dvalid", d_valid, 0);
    chk("rstmid_dout",   d_out,   0);
    chk("rstmid_ready",  in_ready, 1);
    in_data = 8'h55; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rstmid_post_dvalid", d_valid, 0);
      chk("rstmid_post_ready",  in_ready, 1);
    end

    // LSB-first, idle-high instance with 01
    w = 8'h01;
    in_data2 = w; in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("lsb_dvalid", d_valid2, 1);
      chk("lsb_dout",   d_out2,   w[i]);
      tick();
    end
    chk("lsb_end_dvalid", d_valid2, 0);
    chk("lsb_end_dout",   d_out2,   1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
